// File: rtl/aes_inv_round_seq.sv
// aes_inv_round_seq: one-round-per-clock AES decrypt sequencer; define AES_INV_SEQ_B2B_EN for DONE->ROUND back-to-back accept
module aes_inv_round_seq #(
  parameter int NR = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [127:0]      round_key,
  output logic [127:0]      dp_in,
  output logic              dp_last,
  input  logic [127:0]      dp_out,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
  localparam logic [KIDX_W-1:0] KNR = KIDX_W'(NR);
  fsm_t fsm, fsm_nx;
  logic [127:0] state_reg, state_nx;
  logic [KIDX_W-1:0] rnd, rnd_nx;
  assign dp_in = state_reg;
  assign out_data = state_reg;
  // state register, round counter and FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm <= IDLE;
      state_reg <= '0;
      rnd <= '0;
    end else begin
      fsm <= fsm_nx;
      state_reg <= state_nx;
      rnd <= rnd_nx;
    end
  end
  // next state, handshakes and datapath controls; whitening uses key NR on accept
  always_comb begin
    fsm_nx = fsm;
    state_nx = state_reg;
    rnd_nx = rnd;
    in_ready = 1'b0;
    out_valid = 1'b0;
    busy = 1'b0;
    dp_last = 1'b0;
    key_idx = KNR;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = in_data ^ round_key;
          rnd_nx = KNR - 1'b1;
          fsm_nx = ROUND;
        end
      end
      ROUND: begin
        busy = 1'b1;
        key_idx = rnd;
        dp_last = rnd == '0;
        state_nx = dp_out;
        fsm_nx = rnd == '0 ? DONE : ROUND;
        rnd_nx = rnd == '0 ? rnd : rnd - 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        out_valid = 1'b1;
`ifdef AES_INV_SEQ_B2B_EN
        in_ready = out_ready;
        if (out_ready && in_valid) begin
          state_nx = in_data ^ round_key;
          rnd_nx = KNR - 1'b1;
          fsm_nx = ROUND;
        end else if (out_ready) begin
          fsm_nx = IDLE;
        end
`else
        if (out_ready) fsm_nx = IDLE;
`endif
      end
      default: fsm_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_aes_inv_round_seq.sv
// tb_aes_inv_round_seq: scoreboard bench with AES key-store and inverse-round models
module tb_aes_inv_round_seq;
  localparam int NR = 10;
  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2A = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT2A = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT2B = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] PT2B = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
`ifdef AES_INV_SEQ_B2B_EN
  localparam int GAP = NR + 1;
`else
  localparam int GAP = NR + 2;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [127:0] in_data = '0;
  logic in_ready, out_valid, dp_last, busy;
  logic [127:0] out_data, round_key, dp_in, dp_out;
  logic [3:0] key_idx;
  logic [7:0] sbox[256];
  logic [7:0] isbox[256];
  logic [127:0] rk[16];
  logic [127:0] sb[$];
  logic [127:0] exp_cur = '0;
  int rises[$];
  int cyc = 0;
  int acc_edge = 0;
  int exp_k = NR;
  logic prev_ov = 1'b0;
  int checks = 0;
  int errors = 0;

  aes_inv_round_seq #(.NR(NR), .KIDX_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .key_idx(key_idx),
    .round_key(round_key), .dp_in(dp_in), .dp_last(dp_last), .dp_out(dp_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0] a[16], b[16], m[4];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[r+4*c] = isbox[a[r+4*((c-r+4)%4)]] ^ k[127-8*(r+4*c) -: 8];
    if (!last)
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) m[r] = b[4*c+r];
        b[4*c]   = gm(m[0], 8'h0e) ^ gm(m[1], 8'h0b) ^ gm(m[2], 8'h0d) ^ gm(m[3], 8'h09);
        b[4*c+1] = gm(m[0], 8'h09) ^ gm(m[1], 8'h0e) ^ gm(m[2], 8'h0b) ^ gm(m[3], 8'h0d);
        b[4*c+2] = gm(m[0], 8'h0d) ^ gm(m[1], 8'h09) ^ gm(m[2], 8'h0e) ^ gm(m[3], 8'h0b);
        b[4*c+3] = gm(m[0], 8'h0b) ^ gm(m[1], 8'h0d) ^ gm(m[2], 8'h09) ^ gm(m[3], 8'h0e);
      end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o;
  endfunction

  assign round_key = rk[key_idx];
  assign dp_out = inv_round(dp_in, round_key, dp_last);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build_sbox();
    logic [7:0] v, s;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = r <= NR ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  task automatic send(input logic [127:0] d, input logic [127:0] e);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = d;
    exp_cur = e;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("accept", {127'b0, in_ready}, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!busy && !out_valid) break;
    end
    chk("wait_idle", {127'b0, busy}, 128'd0);
  endtask

  task automatic wait_rises(input int cnt);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rises.size() >= cnt) break;
    end
    chk("out_count", 128'(rises.size()), 128'(cnt));
  endtask

  // monitor: latency, key index sequence, scoreboard pop/compare and accept-time push
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      exp_k = NR;
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        rises.push_back(cyc);
        chk("latency", 128'(cyc - acc_edge), 128'(NR));
      end
      prev_ov = out_valid;
      if (busy && !out_valid) begin
        chk("key_idx", 128'(key_idx), 128'(exp_k));
        chk("dp_last", {127'b0, dp_last}, {127'b0, exp_k == 0});
        exp_k--;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h expected no output", out_data);
        end else chk("plaintext", out_data, sb.pop_front());
      end
      if (in_valid && in_ready) begin
        chk("whiten_kidx", 128'(key_idx), 128'(NR));
        sb.push_back(exp_cur);
        acc_edge = cyc + 1;
        exp_k = NR - 1;
      end
    end
  end

  initial begin
    int base;
    build_sbox();
    expand(KEY1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_dp_last", {127'b0, dp_last}, 128'd0);
    chk("rst_key_idx", 128'(key_idx), 128'(NR));
    chk("rst_out_data", out_data, 128'd0);
    send(CT1, PT1);
    wait_idle();
    out_ready = 1'b0;
    send(CT1, PT1);
    wait_rises(2);
    repeat (7) begin
      @(negedge clk);
      chk("stall_valid", {127'b0, out_valid}, 128'd1);
      chk("stall_data", out_data, PT1);
      chk("stall_in_ready", {127'b0, in_ready}, 128'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_valid", {127'b0, out_valid}, 128'd0);
    chk("release_busy", {127'b0, busy}, 128'd0);
    chk("release_in_ready", {127'b0, in_ready}, 128'd1);
    send(CT1, PT1);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_valid", {127'b0, out_valid}, 128'd0);
    chk("abort_in_ready", {127'b0, in_ready}, 128'd1);
    chk("abort_busy", {127'b0, busy}, 128'd0);
    send(CT1, PT1);
    wait_idle();
    send(CT1, PT1);
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b1;
    in_data = CT2A;
    exp_cur = PT2A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();
    expand(KEY2);
    base = rises.size();
    send(CT2A, PT2A);
    send(CT2B, PT2B);
    wait_rises(base + 2);
    if (rises.size() >= base + 2) chk("b2b_gap", 128'(rises[base+1] - rises[base]), 128'(GAP));
    wait_idle();
    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
